// File: rtl/alu_issue_seq_pkg.sv
// Shared constants for the ALU control interface: ALU control codes,
// LEGv8 opcode match patterns, sequencer states and a pattern-match helper.
// Used by the issue sequencer, the opcode decoder and the single-cycle control unit.
package alu_issue_seq_pkg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned OPC_W  = 11;

  // ALU control codes
  localparam logic [CTRL_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR    = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_PASSB = 4'b0111;

  // Opcode patterns as value/mask pairs; a 0 mask bit is a don't-care
  localparam logic [OPC_W-1:0] MASK_FULL = 11'b111_1111_1111;
  localparam logic [OPC_W-1:0] MASK_IMM  = 11'b111_1111_1110;
  localparam logic [OPC_W-1:0] MASK_CB   = 11'b111_1111_1000;

  localparam logic [OPC_W-1:0] OPC_ADD  = 11'b100_0101_1000;
  localparam logic [OPC_W-1:0] OPC_SUB  = 11'b110_0101_1000;
  localparam logic [OPC_W-1:0] OPC_AND  = 11'b100_0101_0000;
  localparam logic [OPC_W-1:0] OPC_ORR  = 11'b101_0101_0000;
  localparam logic [OPC_W-1:0] OPC_ADDI = 11'b100_1000_1000;
  localparam logic [OPC_W-1:0] OPC_SUBI = 11'b110_1000_1000;
  localparam logic [OPC_W-1:0] OPC_LDUR = 11'b111_1100_0010;
  localparam logic [OPC_W-1:0] OPC_STUR = 11'b111_1100_0000;
  localparam logic [OPC_W-1:0] OPC_CBZ  = 11'b101_1010_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // True when opc equals val on every bit selected by mask
  function automatic logic opc_match(input logic [OPC_W-1:0] opc,
                                     input logic [OPC_W-1:0] val,
                                     input logic [OPC_W-1:0] mask);
    return ((opc ^ val) & mask) == '0;
  endfunction

endpackage

// File: rtl/alu_issue_seq_alu_op_decode.sv
// alu_op_decode: combinational LEGv8 opcode -> ALU control code decoder.
// Ports:
//   opcode  in  11-bit instruction field [31:21]
//   ctrl_c  out ALU control code (AND when illegal)
//   legal_c out opcode is decodable
module alu_op_decode
  import alu_issue_seq_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  output logic [CTRL_W-1:0] ctrl_c,
  output logic              legal_c
);

  always_comb begin
    ctrl_c  = ALU_AND;
    legal_c = 1'b1;
    if      (opc_match(opcode, OPC_ADD,  MASK_FULL)) ctrl_c = ALU_ADD;
    else if (opc_match(opcode, OPC_SUB,  MASK_FULL)) ctrl_c = ALU_SUB;
    else if (opc_match(opcode, OPC_AND,  MASK_FULL)) ctrl_c = ALU_AND;
    else if (opc_match(opcode, OPC_ORR,  MASK_FULL)) ctrl_c = ALU_OR;
    else if (opc_match(opcode, OPC_ADDI, MASK_IMM))  ctrl_c = ALU_ADD;
    else if (opc_match(opcode, OPC_SUBI, MASK_IMM))  ctrl_c = ALU_SUB;
    else if (opc_match(opcode, OPC_LDUR, MASK_FULL)) ctrl_c = ALU_ADD;
    else if (opc_match(opcode, OPC_STUR, MASK_FULL)) ctrl_c = ALU_ADD;
    else if (opc_match(opcode, OPC_CBZ,  MASK_CB))   ctrl_c = ALU_PASSB;
    else                                             legal_c = 1'b0;
  end

endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: multi-cycle issue sequencer for the datapath ALU.
// Accepts {Opcode, OpA, OpB} on a valid/ready handshake, drives registered
// ALU control/operand buses for one cycle, captures AluBusW/AluZero and
// returns them on a second valid/ready handshake.
// Ports:
//   CLK, Reset               clock, async active-high reset
//   InValid/InReady          request handshake
//   Opcode, OpA, OpB         request payload
//   ALUCtrl, AluBusA/B       registered ALU inputs
//   AluBusW, AluZero         ALU result and zero flag
//   OutValid/OutReady        result handshake
//   Result, ZeroFlag, IllegalOp  captured response
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned OPCODE_W = OPC_W
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                InValid,
  output logic                InReady,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic [WIDTH-1:0]    OpA,
  input  logic [WIDTH-1:0]    OpB,
  output logic [CTRL_W-1:0]   ALUCtrl,
  output logic [WIDTH-1:0]    AluBusA,
  output logic [WIDTH-1:0]    AluBusB,
  input  logic [WIDTH-1:0]    AluBusW,
  input  logic                AluZero,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [WIDTH-1:0]    Result,
  output logic                ZeroFlag,
  output logic                IllegalOp
);

  seq_state_e        state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  bus_a_q, bus_a_d, bus_b_q, bus_b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d, illegal_q, illegal_d;
  logic              out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] ctrl_c;
  logic              legal_c;

  alu_op_decode u_decode (
    .opcode  (Opcode),
    .ctrl_c  (ctrl_c),
    .legal_c (legal_c)
  );

  // State and datapath registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= ALU_AND;
      bus_a_q     <= '0;
      bus_b_q     <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      bus_a_q     <= bus_a_d;
      bus_b_q     <= bus_b_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state and next-register values; every register holds by default
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    bus_a_d     = bus_a_q;
    bus_b_d     = bus_b_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (InValid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (legal_c) begin
            ctrl_d  = ctrl_c;
            bus_a_d = OpA;
            bus_b_d = OpB;
            state_d = ST_EXEC;
          end else begin
            // Illegal ops bypass the ALU; its input registers stay untouched
            result_d    = '0;
            zero_d      = 1'b0;
            illegal_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        result_d    = AluBusW;
        zero_d      = AluZero;
        illegal_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_valid_q && OutReady) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  assign InReady   = in_ready_q;
  assign ALUCtrl   = ctrl_q;
  assign AluBusA   = bus_a_q;
  assign AluBusB   = bus_b_q;
  assign OutValid  = out_valid_q;
  assign Result    = result_q;
  assign ZeroFlag  = zero_q;
  assign IllegalOp = illegal_q;

endmodule
